// File: rtl/pu_or1k_pfpu32_f2i_if.sv
// rtl/pu_or1k_pfpu32_f2i_if.sv - pipe controls, operand and result bundle of the f2i converter
interface pu_or1k_pfpu32_f2i_if;
  logic        flush_i;
  logic        adv_i;
  logic        start_i;
  logic [31:0] opa_i;
  logic [1:0]  rmode_i;
  logic        f2i_rdy_o;
  logic [31:0] f2i_result_o;
  logic        f2i_inv_o;
  logic        f2i_ix_o;

  modport master (
    output flush_i, adv_i, start_i, opa_i, rmode_i,
    input  f2i_rdy_o, f2i_result_o, f2i_inv_o, f2i_ix_o
  );

  modport slave (
    input  flush_i, adv_i, start_i, opa_i, rmode_i,
    output f2i_rdy_o, f2i_result_o, f2i_inv_o, f2i_ix_o
  );
endinterface

// File: rtl/pu_or1k_pfpu32_f2i.sv
// rtl/pu_or1k_pfpu32_f2i.sv - two-stage float32 to int32 converter (lf.ftoi.s)
module pu_or1k_pfpu32_f2i (
  input  logic                    clk,
  input  logic                    rst,
  pu_or1k_pfpu32_f2i_if.slave     f2i
);

  logic [7:0]  d_exp;
  logic [22:0] d_fract;
  logic [23:0] d_m24;
  logic        d_nan, d_inf, d_ovf;
  logic [31:0] d_mag;
  logic        d_guard, d_sticky;
  logic [7:0]  d_lsh;
  logic [7:0]  d_rsh;
  logic [47:0] d_shifted;

  always_comb begin
    d_exp     = f2i.opa_i[30:23];
    d_fract   = f2i.opa_i[22:0];
    d_m24     = {(d_exp != 8'd0), d_fract};
    d_nan     = (d_exp == 8'd255) && (d_fract != 23'd0);
    d_inf     = (d_exp == 8'd255) && (d_fract == 23'd0);
    // -2^31 is the one representable value with an exponent of 158
    d_ovf     = (d_exp >= 8'd158) && (f2i.opa_i != 32'hCF00_0000);
    d_mag     = 32'd0;
    d_guard   = 1'b0;
    d_sticky  = 1'b0;
    d_lsh     = 8'd0;
    d_rsh     = 8'd0;
    d_shifted = 48'd0;
    if (d_exp >= 8'd150) begin
      d_lsh = d_exp - 8'd150;
      d_mag = {8'd0, d_m24} << d_lsh;
    end else if (d_exp >= 8'd126) begin
      // low half of the wide shift collects the discarded fraction bits
      d_rsh     = 8'd150 - d_exp;
      d_shifted = {d_m24, 24'd0} >> d_rsh;
      d_mag     = {8'd0, d_shifted[47:24]};
      d_guard   = d_shifted[23];
      d_sticky  = |d_shifted[22:0];
    end else begin
      d_sticky = (d_m24 != 24'd0);
    end
  end

  logic        s1_valid;
  logic        s1_sign, s1_nan, s1_inf, s1_ovf;
  logic [1:0]  s1_rmode;
  logic [31:0] s1_mag;
  logic        s1_guard, s1_sticky;

  logic        r_rdy;
  logic [31:0] r_result;
  logic        r_inv, r_ix;

  logic        c_inc;
  logic [31:0] c_rmag;
  logic [31:0] c_signed;
  logic        c_invalid;
  logic [31:0] c_result;
  logic        c_ix;

  always_comb begin
    c_inc = 1'b0;
    case (s1_rmode)
      2'b00:   c_inc = s1_guard & (s1_sticky | s1_mag[0]);
      2'b01:   c_inc = 1'b0;
      2'b10:   c_inc = ~s1_sign & (s1_guard | s1_sticky);
      default: c_inc = s1_sign & (s1_guard | s1_sticky);
    endcase
    c_rmag    = s1_mag + {31'd0, c_inc};
    c_signed  = s1_sign ? (~c_rmag + 32'd1) : c_rmag;
    c_invalid = s1_nan | s1_inf | s1_ovf;
    c_result  = c_signed;
    if (s1_nan)
      c_result = 32'h7FFF_FFFF;
    else if (s1_inf | s1_ovf)
      c_result = s1_sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
    c_ix = (s1_guard | s1_sticky) & ~c_invalid;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_sign   <= 1'b0;
      s1_nan    <= 1'b0;
      s1_inf    <= 1'b0;
      s1_ovf    <= 1'b0;
      s1_rmode  <= 2'b00;
      s1_mag    <= 32'd0;
      s1_guard  <= 1'b0;
      s1_sticky <= 1'b0;
      r_rdy     <= 1'b0;
      r_result  <= 32'd0;
      r_inv     <= 1'b0;
      r_ix      <= 1'b0;
    end else begin
      if (f2i.flush_i) begin
        s1_valid <= 1'b0;
        r_rdy    <= 1'b0;
      end else if (f2i.adv_i) begin
        s1_valid <= f2i.start_i;
        r_rdy    <= s1_valid;
      end
      if (f2i.adv_i) begin
        s1_sign   <= f2i.opa_i[31];
        s1_nan    <= d_nan;
        s1_inf    <= d_inf;
        s1_ovf    <= d_ovf;
        s1_rmode  <= f2i.rmode_i;
        s1_mag    <= d_mag;
        s1_guard  <= d_guard;
        s1_sticky <= d_sticky;
      end
      // results and flags only move when a real conversion leaves stage 1
      if (f2i.adv_i && s1_valid) begin
        r_result <= c_result;
        r_inv    <= c_invalid;
        r_ix     <= c_ix;
      end
    end
  end

  assign f2i.f2i_rdy_o    = r_rdy;
  assign f2i.f2i_result_o = r_result;
  assign f2i.f2i_inv_o    = r_inv;
  assign f2i.f2i_ix_o     = r_ix;

endmodule

// File: tb/tb_pu_or1k_pfpu32_f2i.sv
// tb/tb_pu_or1k_pfpu32_f2i.sv - scoreboard bench for the float32 to int32 converter
module tb_pu_or1k_pfpu32_f2i;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pu_or1k_pfpu32_f2i_if bus ();

  pu_or1k_pfpu32_f2i dut (
    .clk (clk),
    .rst (rst),
    .f2i (bus)
  );

  typedef struct packed {
    logic [31:0] opa;
    logic [1:0]  rm;
    logic [31:0] res;
    logic        inv;
    logic        ix;
  } vec_t;

  typedef struct packed {
    int          id;
    logic [31:0] res;
    logic        inv;
    logic        ix;
  } exp_t;

  vec_t vecs [16];
  exp_t sb[$];
  int   n_pass   = 0;
  int   n_total  = 0;
  int   n_pushed = 0;
  int   n_popped = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h required %h", tag, obs, exp);
  endtask

  always @(negedge clk) begin
    if (bus.adv_i === 1'b1 && bus.f2i_rdy_o === 1'b1) begin
      if (sb.size() == 0) begin
        n_total++;
        $error("FAIL unexpected_rdy: observed rdy=1 result %h required no pending result",
               bus.f2i_result_o);
      end else begin
        exp_t e;
        e = sb.pop_front();
        n_popped++;
        chk($sformatf("result_%0d", e.id), bus.f2i_result_o, e.res);
        chk($sformatf("inv_%0d", e.id), {31'd0, bus.f2i_inv_o}, {31'd0, e.inv});
        chk($sformatf("ix_%0d", e.id), {31'd0, bus.f2i_ix_o}, {31'd0, e.ix});
      end
    end
  end

  task automatic send(input vec_t v, input int id, input bit push);
    exp_t e;
    bus.start_i = 1'b1;
    bus.adv_i   = 1'b1;
    bus.opa_i   = v.opa;
    bus.rmode_i = v.rm;
    if (push) begin
      e.id  = id;
      e.res = v.res;
      e.inv = v.inv;
      e.ix  = v.ix;
      sb.push_back(e);
      n_pushed++;
    end
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 20 && sb.size() != 0; k++) begin
      @(posedge clk);
      #1;
    end
    chk(tag, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    vecs = '{
      '{32'h3FC0_0000, 2'd0, 32'h0000_0002, 1'b0, 1'b1},
      '{32'h3FC0_0000, 2'd1, 32'h0000_0001, 1'b0, 1'b1},
      '{32'h4020_0000, 2'd0, 32'h0000_0002, 1'b0, 1'b1},
      '{32'h42F6_0000, 2'd0, 32'h0000_007B, 1'b0, 1'b0},
      '{32'hBF00_0000, 2'd2, 32'h0000_0000, 1'b0, 1'b1},
      '{32'hBF00_0000, 2'd3, 32'hFFFF_FFFF, 1'b0, 1'b1},
      '{32'h0000_0001, 2'd2, 32'h0000_0001, 1'b0, 1'b1},
      '{32'hCF00_0000, 2'd0, 32'h8000_0000, 1'b0, 1'b0},
      '{32'h4F00_0000, 2'd0, 32'h7FFF_FFFF, 1'b1, 1'b0},
      '{32'h4EFF_FFFF, 2'd0, 32'h7FFF_FF80, 1'b0, 1'b0},
      '{32'hFF80_0000, 2'd0, 32'h8000_0000, 1'b1, 1'b0},
      '{32'h7FC0_0000, 2'd0, 32'h7FFF_FFFF, 1'b1, 1'b0},
      '{32'hBFC0_0000, 2'd0, 32'hFFFF_FFFE, 1'b0, 1'b1},
      '{32'h8000_0000, 2'd0, 32'h0000_0000, 1'b0, 1'b0},
      '{32'h4020_0000, 2'd2, 32'h0000_0003, 1'b0, 1'b1},
      '{32'hCF80_0000, 2'd0, 32'h8000_0000, 1'b1, 1'b0}
    };

    rst         = 1'b1;
    bus.flush_i = 1'b0;
    bus.adv_i   = 1'b0;
    bus.start_i = 1'b0;
    bus.opa_i   = 32'd0;
    bus.rmode_i = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rdy", {31'd0, bus.f2i_rdy_o}, 32'd0);
    chk("reset_result", bus.f2i_result_o, 32'd0);
    chk("reset_inv", {31'd0, bus.f2i_inv_o}, 32'd0);
    chk("reset_ix", {31'd0, bus.f2i_ix_o}, 32'd0);
    rst       = 1'b0;
    bus.adv_i = 1'b1;
    @(posedge clk);
    #1;

    // back-to-back stream of every directed vector
    for (int i = 0; i < 16; i++) send(vecs[i], i, 1'b1);
    drain("stream_drain");

    // stall: three adv-low cycles between issue and completion
    send(vecs[3], 100, 1'b1);
    bus.adv_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("stall_rdy_low_%0d", k), {31'd0, bus.f2i_rdy_o}, 32'd0);
      @(posedge clk);
      #1;
    end
    bus.adv_i = 1'b1;
    @(negedge clk);
    chk("stall_rdy_low_3", {31'd0, bus.f2i_rdy_o}, 32'd0);
    @(posedge clk);
    #1;
    chk("stall_rdy_high", {31'd0, bus.f2i_rdy_o}, 32'd1);
    drain("stall_drain");

    // flush kills the in-flight op and the op offered alongside the flush
    send(vecs[0], 200, 1'b0);
    bus.flush_i = 1'b1;
    send(vecs[1], 201, 1'b0);
    bus.flush_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("flush_rdy_low_%0d", k), {31'd0, bus.f2i_rdy_o}, 32'd0);
      @(posedge clk);
      #1;
    end
    send(vecs[9], 202, 1'b1);
    drain("flush_recover_drain");

    // asynchronous reset with one result presented and one op in stage 1
    send(vecs[3], 300, 1'b0);
    send(vecs[6], 301, 1'b0);
    chk("pre_rst_rdy", {31'd0, bus.f2i_rdy_o}, 32'd1);
    rst = 1'b1;
    #1;
    chk("async_rst_rdy", {31'd0, bus.f2i_rdy_o}, 32'd0);
    chk("async_rst_result", bus.f2i_result_o, 32'd0);
    chk("async_rst_inv", {31'd0, bus.f2i_inv_o}, 32'd0);
    chk("async_rst_ix", {31'd0, bus.f2i_ix_o}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("post_rst_rdy_low_%0d", k), {31'd0, bus.f2i_rdy_o}, 32'd0);
      @(posedge clk);
      #1;
    end
    send(vecs[12], 302, 1'b1);
    drain("post_rst_drain");

    chk("popped_vs_pushed", 32'(n_popped), 32'(n_pushed));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pu_or1k_pfpu32_f2i.md
Name: pu_or1k_pfpu32_f2i

Overview:
- Two-stage pipelined converter from IEEE-754 single-precision float to signed 32-bit integer (lf.ftoi.s) inside the pfpu32 unit.
- It is the reverse-direction counterpart of the int-to-float path.
- Stage 1 decodes the operand and aligns the mantissa. Stage 2 rounds per the FPCSR rounding mode, applies sign and saturation, and produces the invalid and inexact flags.
- Shares the pfpu32 pipe controls (adv_i, flush_i, start_i) with the other pfpu32 sub-units.

Parameters:
- none

Ports:
- clk           input   1   clock
- rst           input   1   asynchronous reset, active-high
- flush_i       input   1   flush pipe; kills all in-flight conversions
- adv_i         input   1   advance pipe; both stages update only when 1
- start_i       input   1   operand on opa_i is a valid f2i request
- opa_i         input   32  float operand {sign, exp[7:0], fract[22:0]}
- rmode_i       input   2   rounding mode: 00 nearest-even, 01 toward zero, 10 toward +inf, 11 toward -inf
- f2i_rdy_o     output  1   result valid (one-cycle qualifier per conversion while adv_i=1)
- f2i_result_o  output  32  signed integer result
- f2i_inv_o     output  1   invalid: NaN, infinity or out-of-range
- f2i_ix_o      output  1   inexact: fraction bits discarded; never set together with inv

Behaviour:
- Reset (async, rst=1): s1 valid, f2i_rdy_o, f2i_result_o, f2i_inv_o and f2i_ix_o all go to 0. Stage-1 data registers also clear to 0.
- Pipeline enable: both stages register only when adv_i=1. With adv_i=0 every register holds, including rdy. This is a stall, not a drop.
- Latency: a result appears 2 adv cycles after start_i is sampled.
- Valid chain on adv_i=1: s1_valid <= start_i, then f2i_rdy_o <= s1_valid.
- flush_i=1 clears s1_valid and f2i_rdy_o on that edge, regardless of adv_i. flush_i has priority over adv_i. Data registers are don't-care after a flush.
- Stage 1 decode: e = opa_i[30:23], m24 = {e!=0, fract}, where denormals are treated as hidden bit 0.
  - nan = (e==255 && fract!=0)
  - inf = (e==255 && fract==0)
  - ovf = (e>=158), except exactly 0xCF000000 (-2^31), which is valid.
- Stage 1 alignment, latched together with sign, nan, inf, ovf and rmode:
  - e>=150: mag32 = m24 << (e-150); guard = 0; sticky = 0 (the result is exact).
  - 126<=e<150: mag32 = m24 >> (150-e); guard = the bit just below the LSB; sticky = OR of all lower shifted-out bits.
  - e<126: mag32 = 0; guard = 0; sticky = (m24!=0).
- Stage 2 round-up decision (inc):
  - 00 nearest-even: inc = guard & (sticky | mag32[0]).
  - 01 toward zero: inc = 0.
  - 10 toward +inf: inc = ~sign & (guard|sticky).
  - 11 toward -inf: inc = sign & (guard|sticky).
- Stage 2 result: rmag = mag32 + inc, in 32 bits with no carry-out. For e<=157 with rounding, rmag <= 2^31-1, so no post-round overflow is possible.
- Stage 2 sign: result = sign ? -rmag : rmag. -0 yields 0x00000000.
- Invalid cases:
  - nan → 0x7FFFFFFF.
  - inf or ovf with sign=0 → 0x7FFFFFFF.
  - inf or ovf with sign=1 → 0x80000000.
  - In all three, f2i_inv_o=1 and f2i_ix_o=0.
- Inexact: f2i_ix_o = (guard|sticky) & ~invalid.
- The flags are valid only when f2i_rdy_o=1. Outside that they hold their last value.
- Back-to-back: with adv_i held at 1, a new operand is accepted every cycle, giving throughput of 1/cycle.
- Reset mid-operation: in-flight work is lost and f2i_rdy_o stays 0 until 2 adv cycles after the next start_i.

Test Plan:
- Rounding: 0x3FC00000 (1.5) with rmode 00 → 2, ix=1. Same operand with rmode 01 → 1, ix=1. 0x40200000 (2.5) with rmode 00 → 2, ix=1. 0x42F60000 (123.0) → 123, ix=0, inv=0.
- Directed modes: 0xBF000000 (-0.5) with rmode 10 → 0x00000000, ix=1. Same operand with rmode 11 → 0xFFFFFFFF, ix=1. 0x00000001 (denormal) with rmode 10 → 1, ix=1.
- Range edges:
  - 0xCF000000 → 0x80000000, inv=0, ix=0.
  - 0x4F000000 → 0x7FFFFFFF, inv=1.
  - 0x4EFFFFFF → 0x7FFFFF80, inv=0.
  - 0xFF800000 (-inf) → 0x80000000, inv=1.
  - 0x7FC00000 (NaN) → 0x7FFFFFFF, inv=1, ix=0.
- Pipeline stall: start_i on cycle n with adv_i=1, then adv_i=0 for cycles n+1..n+3, then 1. f2i_rdy_o rises on the edge ending cycle n+4 and the result matches the operand.
- Flush: start_i on cycle n, flush_i=1 on cycle n+1 → f2i_rdy_o never asserts for that op. A start_i on cycle n+1 with flush_i=1 is also dropped.
- Reset: assert rst asynchronously while s1_valid=1 → all outputs 0 immediately, and no rdy appears after rst releases without a new start_i. Also run a back-to-back stream of 8 operands with adv_i=1 → 8 consecutive rdy pulses with results in order.
